// File: rtl/r4k_dbus_bridge.sv
// Data-side bridge: captures one 64-bit core load/store and replays it as up to
// two 32-bit valid/ready bus beats, with sticky error and timeout reporting.
module r4k_dbus_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       core_address,
  input  logic [63:0]       core_wdata,
  input  logic              core_read,
  input  logic              core_write,
  input  logic [7:0]        core_mask,
  output logic [63:0]       core_rdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  output logic              bus_we,
  output logic              bus_valid,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_error,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int unsigned TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW:0] TO_LIM = (TW + 1)'(TIMEOUT);
  localparam bit          TO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-4:0] base_q;
  logic [63:0]       wdata_q;
  logic [7:0]        mask_q;
  logic              we_q;
  logic [TW-1:0]     tcnt_q;

  logic              req_c;
  logic              active_c;
  logic              timeout_c;
  logic              fail_c;
  logic              beat_ok_c;
  logic [7:0]        eff_mask_c;
  logic              unused_addr;

  // Only the word-aligned part of the address below ADDR_W reaches the bus.
  assign unused_addr = ^core_address;

  // A zero-mask read fetches the full doubleword.
  assign req_c      = core_read | core_write;
  assign eff_mask_c = (!core_write && core_mask == 8'h00) ? 8'hFF : core_mask;
  assign active_c   = (state_q == LO) || (state_q == HI);
  assign timeout_c  = TO_EN && active_c && !bus_ready &&
                      (({1'b0, tcnt_q} + (TW + 1)'(1)) == TO_LIM);
  assign fail_c     = (active_c && bus_ready && bus_error) || timeout_c;
  assign beat_ok_c  = active_c && bus_ready && !bus_error;
  assign core_stall = ((state_q == IDLE) && req_c) || active_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and bus beat decode from the latched request.
  always_comb begin
    state_d   = state_q;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (|eff_mask_c[3:0])      state_d = LO;
          else if (|eff_mask_c[7:4]) state_d = HI;
          else                       state_d = DONE;
        end
      end
      LO: begin
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = {base_q, 3'b000};
        bus_wdata = wdata_q[31:0];
        bus_wstrb = mask_q[3:0];
        if (fail_c)         state_d = DONE;
        else if (bus_ready) state_d = (|mask_q[7:4]) ? HI : DONE;
      end
      HI: begin
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = {base_q, 3'b100};
        bus_wdata = wdata_q[63:32];
        bus_wstrb = mask_q[7:4];
        if (fail_c || bus_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and read data assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      core_rdata <= '0;
    end else if ((state_q == IDLE) && req_c) begin
      base_q     <= core_address[ADDR_W-1:3];
      wdata_q    <= core_wdata;
      mask_q     <= eff_mask_c;
      we_q       <= core_write;
      core_rdata <= '0;
    end else if (beat_ok_c && !we_q) begin
      if (state_q == LO) core_rdata[31:0]  <= bus_rdata;
      else               core_rdata[63:32] <= bus_rdata;
    end
  end

  // Per-beat wait counter; restarts whenever a beat ends or the bus is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                tcnt_q <= '0;
    else if (!active_c || bus_ready || timeout_c) tcnt_q <= '0;
    else                                         tcnt_q <= tcnt_q + TW'(1);
  end

  // Sticky error: only the first failing beat address is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (fail_c && !err_flag) begin
      err_flag <= 1'b1;
      err_addr <= bus_addr;
    end
  end

endmodule

// File: tb/tb_r4k_dbus_bridge.sv
// Self-checking bench for r4k_dbus_bridge: directed and random accesses against
// a memory-backed slave and a transaction-level expectation model.
module tb_r4k_dbus_bridge;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam int          NEVER   = 255;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [63:0]       core_address;
  logic [63:0]       core_wdata;
  logic              core_read;
  logic              core_write;
  logic [7:0]        core_mask;
  logic [63:0]       core_rdata;
  logic              core_stall;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_we;
  logic              bus_valid;
  logic              bus_ready;
  logic [31:0]       bus_rdata;
  logic              bus_error;
  logic              err_flag;
  logic [ADDR_W-1:0] err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [31:0]];
  logic        exp_err_flag;
  logic [31:0] exp_err_addr;
  logic [63:0] last_rd;

  r4k_dbus_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_address(core_address), .core_wdata(core_wdata),
    .core_read(core_read), .core_write(core_write), .core_mask(core_mask),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_we(bus_we), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bus_error(bus_error),
    .err_flag(err_flag), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic note_err(input logic [31:0] a);
    if (!exp_err_flag) begin
      exp_err_flag = 1'b1;
      exp_err_addr = a;
    end
  endtask

  // One core access: wN = wait states of the Nth issued beat (>= TIMEOUT means
  // the slave never answers), eN = slave reports an error on that beat.
  task automatic access(input string tag, input bit wr, input bit both,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] mask, input int w0, input int w1,
                        input bit e0, input bit e1);
    logic [7:0]  m;
    logic [31:0] baddr [2];
    logic [3:0]  bstrb [2];
    logic [31:0] bwd   [2];
    int          bwait [2];
    bit          berr  [2];
    logic [31:0] word;
    logic [63:0] exp_rd;
    int          nb, lat, bi, wc;

    m  = (!wr && mask == 8'h00) ? 8'hFF : mask;
    nb = 0;
    if (m[3:0] != 4'h0) begin
      baddr[nb] = {addr[31:3], 3'b000}; bstrb[nb] = m[3:0]; bwd[nb] = wd[31:0]; nb++;
    end
    if (m[7:4] != 4'h0) begin
      baddr[nb] = {addr[31:3], 3'b100}; bstrb[nb] = m[7:4]; bwd[nb] = wd[63:32]; nb++;
    end
    bwait[0] = w0; bwait[1] = w1; berr[0] = e0; berr[1] = e1;

    // Expected outcome: latency, read data, memory and error effects.
    lat    = 1;
    exp_rd = '0;
    for (int b = 0; b < nb; b++) begin
      if (bwait[b] >= int'(TIMEOUT)) begin
        lat += int'(TIMEOUT);
        note_err(baddr[b]);
        break;
      end
      lat += bwait[b] + 1;
      if (berr[b]) begin
        note_err(baddr[b]);
        break;
      end
      if (wr) begin
        word = mem_rd(baddr[b]);
        for (int k = 0; k < 4; k++)
          if (bstrb[b][k]) word[8*k +: 8] = bwd[b][8*k +: 8];
        mem[baddr[b]] = word;
      end else if (baddr[b][2]) begin
        exp_rd[63:32] = mem_rd(baddr[b]);
      end else begin
        exp_rd[31:0] = mem_rd(baddr[b]);
      end
    end
    if (wr) exp_rd = '0;

    @(negedge clk);
    check({tag, ".idle_valid"}, 128'(bus_valid), 128'(1'b0));
    check({tag, ".idle_stall"}, 128'(core_stall), 128'(1'b0));
    check({tag, ".idle_rdata"}, 128'(core_rdata), 128'(last_rd));
    core_address = addr;
    core_wdata   = wd;
    core_mask    = mask;
    core_write   = wr;
    core_read    = !wr || both;
    #1;
    check({tag, ".req_stall"}, 128'(core_stall), 128'(1'b1));

    bi = 0;
    wc = 0;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      bus_ready = 1'b0;
      bus_error = 1'b0;
      bus_rdata = $urandom;
      if (n == lat) begin
        check({tag, ".done_valid"}, 128'(bus_valid), 128'(1'b0));
        check({tag, ".done_stall"}, 128'(core_stall), 128'(1'b0));
        check({tag, ".rdata"}, 128'(core_rdata), 128'(exp_rd));
        check({tag, ".err_flag"}, 128'(err_flag), 128'(exp_err_flag));
        check({tag, ".err_addr"}, 128'(err_addr), 128'(exp_err_addr));
        core_read  = 1'b0;
        core_write = 1'b0;
      end else begin
        check({tag, ".beat_valid"}, 128'(bus_valid), 128'(1'b1));
        check({tag, ".beat_stall"}, 128'(core_stall), 128'(1'b1));
        check({tag, ".beat"}, 128'({bus_addr, bus_wstrb, bus_we, bus_wdata}),
              128'({baddr[bi], bstrb[bi], wr, bwd[bi]}));
        if (bwait[bi] < int'(TIMEOUT) && wc == bwait[bi]) begin
          bus_ready = 1'b1;
          bus_error = berr[bi];
          bus_rdata = mem_rd(baddr[bi]);
          bi++;
          wc = 0;
        end else begin
          wc++;
        end
      end
    end
    last_rd = exp_rd;
  endtask

  initial begin
    logic        wr, both, e0, e1;
    logic [63:0] a, d;
    logic [7:0]  m;
    int          w0, w1;

    reset_n      = 1'b0;
    core_address = '0;
    core_wdata   = '0;
    core_read    = 1'b0;
    core_write   = 1'b0;
    core_mask    = '0;
    bus_ready    = 1'b0;
    bus_rdata    = '0;
    bus_error    = 1'b0;
    exp_err_flag = 1'b0;
    exp_err_addr = '0;
    last_rd      = '0;

    repeat (3) @(negedge clk);
    check("rst.bus_valid", 128'(bus_valid), 128'(1'b0));
    check("rst.bus_we", 128'(bus_we), 128'(1'b0));
    check("rst.bus_wstrb", 128'(bus_wstrb), 128'(4'h0));
    check("rst.bus_addr", 128'(bus_addr), 128'(32'h0));
    check("rst.bus_wdata", 128'(bus_wdata), 128'(32'h0));
    check("rst.err_flag", 128'(err_flag), 128'(1'b0));
    check("rst.err_addr", 128'(err_addr), 128'(32'h0));
    check("rst.core_rdata", 128'(core_rdata), 128'(64'h0));
    check("rst.core_stall", 128'(core_stall), 128'(1'b0));
    reset_n = 1'b1;

    mem[32'h1000] = 32'h1111_1111;
    mem[32'h1004] = 32'h2222_2222;
    access("rd_full", 1'b0, 1'b0, 64'h1000, 64'h0, 8'hFF, 0, 0, 1'b0, 1'b0);
    check("rd_full.value", 128'(core_rdata), 128'(64'h2222_2222_1111_1111));

    access("wr_hi_wait", 1'b1, 1'b0, 64'h1000, 64'hAABB_CCDD_0000_0000, 8'hF0, 2, 0, 1'b0, 1'b0);
    access("rd_back", 1'b0, 1'b0, 64'h1005, 64'h0, 8'hF0, 1, 0, 1'b0, 1'b0);
    check("rd_back.value", 128'(core_rdata), 128'(64'hAABB_CCDD_0000_0000));

    access("rd_mask0", 1'b0, 1'b0, 64'h2008, 64'h0, 8'h00, 0, 1, 1'b0, 1'b0);
    access("wr_mask0", 1'b1, 1'b1, 64'h2010, 64'h1234_5678_9ABC_DEF0, 8'h00, 0, 0, 1'b0, 1'b0);

    access("rd_err_lo", 1'b0, 1'b0, 64'h3000, 64'h0, 8'hFF, 0, 0, 1'b1, 1'b0);
    check("rd_err_lo.err_addr", 128'(err_addr), 128'(32'h3000));
    access("wr_err_hi", 1'b1, 1'b0, 64'h4000, 64'hFFFF_0000_FFFF_0000, 8'hFF, 0, 0, 1'b0, 1'b1);
    check("wr_err_hi.err_addr_kept", 128'(err_addr), 128'(32'h3000));

    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      both = 1'($urandom_range(0, 1));
      a    = {32'($urandom), 16'h0, 8'h60, 5'($urandom), 3'($urandom)};
      d    = {32'($urandom), 32'($urandom)};
      m    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      w0   = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 2));
      w1   = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 2));
      e0   = ($urandom_range(0, 11) == 0);
      e1   = ($urandom_range(0, 11) == 0);
      access("rand", wr, both, a, d, m, w0, w1, e0, e1);
    end

    // Reset in the middle of a waiting beat.
    @(negedge clk);
    core_address = 64'h6000;
    core_mask    = 8'hFF;
    core_write   = 1'b0;
    core_read    = 1'b1;
    bus_ready    = 1'b0;
    bus_error    = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.pre_valid", 128'(bus_valid), 128'(1'b1));
    #2;
    reset_n   = 1'b0;
    core_read = 1'b0;
    #1;
    check("midrst.bus_valid", 128'(bus_valid), 128'(1'b0));
    check("midrst.core_stall", 128'(core_stall), 128'(1'b0));
    check("midrst.bus_addr", 128'(bus_addr), 128'(32'h0));
    check("midrst.bus_wstrb", 128'(bus_wstrb), 128'(4'h0));
    check("midrst.err_flag", 128'(err_flag), 128'(1'b0));
    check("midrst.err_addr", 128'(err_addr), 128'(32'h0));
    check("midrst.core_rdata", 128'(core_rdata), 128'(64'h0));
    exp_err_flag = 1'b0;
    exp_err_addr = '0;
    last_rd      = '0;
    @(negedge clk);
    reset_n = 1'b1;

    access("timeout", 1'b0, 1'b0, 64'h5000, 64'h0, 8'hFF, NEVER, 0, 1'b0, 1'b0);
    check("timeout.err_flag", 128'(err_flag), 128'(1'b1));
    check("timeout.err_addr", 128'(err_addr), 128'(32'h5000));
    access("after_to", 1'b0, 1'b0, 64'h1000, 64'h0, 8'h0F, 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/r4k_dbus_bridge.md
# r4k_dbus_bridge

Data-side bus bridge between the `r4k_core` data port and the 32-bit system memory bus. It captures the core's single 64-bit load/store request and holds the core with `core_stall`. It splits the request into at most two 32-bit valid/ready beats and returns assembled read data. Bus errors and timeouts are flagged, so a stuck slave cannot hang the pipeline silently.

## Interface
Parameters:
- `ADDR_W`, 32: bus address width; the bridge uses `core_address[ADDR_W-1:0]`.
- `TIMEOUT`, 255: maximum cycles a beat may wait for `bus_ready`; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `core_address` in 64: byte address from the core.
- `core_wdata` in 64: store data.
- `core_read` in 1: load request.
- `core_write` in 1: store request.
- `core_mask` in 8: byte enables; bit i enables byte i.
- `core_rdata` out 64: assembled load data.
- `core_stall` out 1: the core holds its request and pipeline while this is high.
- `bus_addr` out ADDR_W: word address of the current beat.
- `bus_wdata` out 32: beat write data.
- `bus_wstrb` out 4: beat byte strobes.
- `bus_we` out 1: 1 = write beat.
- `bus_valid` out 1: beat request.
- `bus_ready` in 1: slave accepts or completes the beat.
- `bus_rdata` in 32: read data, valid when `bus_valid && bus_ready`.
- `bus_error` in 1: slave error, qualified by `bus_ready`.
- `err_flag` out 1: sticky error indicator.
- `err_addr` out ADDR_W: beat address of the first error.

## Operation
States: IDLE, LO, HI, DONE.

IDLE:
- On `core_read || core_write`, latch address, wdata, mask, and direction. Write wins if both are asserted.
- Compute beat needs:
  - need_lo = `|mask[3:0]`; need_hi = `|mask[7:4]`.
  - A read with `mask == 0` sets both needs.
  - A write with `mask == 0` needs no beats and goes straight to DONE.
- Next state is LO if need_lo, else HI if need_hi, else DONE.
- Clear the `core_rdata` capture register to 0.

LO beat:
- `bus_addr = {addr[ADDR_W-1:3], 3'b000}`.
- `bus_wstrb = mask[3:0]`, `bus_wdata = wdata[31:0]`.

HI beat:
- `bus_addr = {addr[ADDR_W-1:3], 3'b100}`.
- `bus_wstrb = mask[7:4]`, `bus_wdata = wdata[63:32]`.

Beat rules:
- `bus_we` = latched direction.
- For reads, `bus_wstrb` carries the mask slice, or `4'hF` when the mask was 0.
- `bus_valid` is high throughout LO/HI. Address, data, strobe, and `bus_we` stay stable until `bus_ready`.
- On `bus_ready`:
  - A read stores `bus_rdata` into the matching half of `core_rdata`.
  - LO goes to HI if need_hi, else to DONE. HI goes to DONE.
- `bus_error && bus_ready`, or a timeout:
  - Abandon remaining beats and go to DONE.
  - Halves not fetched stay 0.
  - If `err_flag` was 0, set it and load `err_addr` with the beat address.

DONE:
- `core_stall` = 0 for exactly one cycle, then return to IDLE.
- `core_rdata` holds until the next capture in IDLE.

Stall and flags:
- `core_stall = (state==IDLE && (core_read||core_write)) || state==LO || state==HI`.
- `err_flag` and `err_addr` clear only on reset.

Timeout:
- A counter is cleared on entry to each beat and increments every cycle `bus_valid && !bus_ready`.
- When it reaches TIMEOUT with `TIMEOUT != 0`, the beat ends as an error on that cycle. `bus_valid` drops on the next cycle.

## Timing
- Reset values: state IDLE, `core_rdata` 0, `bus_valid` 0, `bus_we` 0, `bus_wstrb` 0, `bus_addr` 0, `bus_wdata` 0, `err_flag` 0, `err_addr` 0.
- `core_stall` is combinational from state and the core request. All bus outputs are registered or decoded from registered state.
- Zero-wait-state latency, counted from the request cycle to the DONE cycle:
  - 2-beat access: 3 cycles.
  - 1-beat access: 2 cycles.
  - Zero-mask write: 1 cycle.
- Each wait-state cycle adds 1.
- A request present during DONE is the completed request; the new request is seen in the following IDLE cycle.
- Reset asserted mid-beat drops `bus_valid` immediately and abandons the access. The core is held in reset by the same signal.

## Test plan
- Read, `core_address=0x1000`, mask `0xFF`, zero-wait slave returning `0x11111111` then `0x22222222`:
  - Beats at `0x1000` and `0x1004`.
  - `core_rdata=0x2222222211111111` in DONE, 3 cycles after the request.
- Write, mask `0xF0`, `wdata=0xAABBCCDD_00000000`, slave with 2 wait states:
  - Single beat at `addr|4`, `wstrb=0xF`, `wdata=0xAABBCCDD`.
  - `bus_valid` stable for 3 cycles; DONE at cycle 4.
- Read with mask `0x00` at `0x2008`:
  - Both beats fetched, `wstrb=0xF` on each.
- Write with mask `0x00`:
  - No `bus_valid`; `core_stall` high for 1 cycle, then DONE.
- `bus_error` on LO beat of a 2-beat read at `0x3000`:
  - HI beat skipped, `core_rdata=0`, `err_flag=1`, `err_addr=0x3000`.
  - A second error later leaves `err_addr` unchanged.
- TIMEOUT=4, slave never ready:
  - Timeout on the 4th waiting cycle, `err_flag=1`.
  - Core released in the next DONE.
  - `reset_n` low mid-beat clears all outputs asynchronously.
